// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pipe_hazard_ctrl : forwarding, load-use/branch hazards, multi-cycle Execute  |
// | sequencing. Optional perf counters enabled by macro HAZARD_PERF_EN.          |
// | Revision 1.0                                                                 |
// +-----------------------------------------------------------------------------+
module pipe_hazard_ctrl #(
   parameter int MC_LATENCY = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] Rs1D,
   input  logic [4:0] Rs2D,
   input  logic [4:0] Rs1E,
   input  logic [4:0] Rs2E,
   input  logic [4:0] RdE,
   input  logic [4:0] RdM,
   input  logic [4:0] RdW,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic       LoadE,
   input  logic       PCSrcE,
   input  logic       MultiE,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       StallF,
   output logic       StallD,
   output logic       StallE,
   output logic       FlushD,
   output logic       FlushE,
   output logic       FlushM,
   output logic       BusyE
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] StallCycles,
   output logic [31:0] FlushCount
`endif
);

   localparam int CNT_W = $clog2(MC_LATENCY);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // A two-cycle op has no BUSY phase: one stall cycle, then release.
   localparam logic [1:0]       C_FIRST_STATE = (MC_LATENCY > 2) ? BUSY : DONE;
   localparam logic [CNT_W-1:0] C_CNT_INIT    = CNT_W'(MC_LATENCY - 2);
   localparam logic [CNT_W-1:0] C_CNT_ONE     = CNT_W'(1);

   if (MC_LATENCY < 2 || MC_LATENCY > 16) begin : g_bad_latency
      $error("MC_LATENCY must be in 2..16");
   end

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lwStall;
   logic             mcStall;

   always_comb begin
      ForwardAE = 2'b00;
      if (RegWriteM && (RdM == Rs1E) && (RdM != 5'd0))
         ForwardAE = 2'b10;
      else if (RegWriteW && (RdW == Rs1E) && (RdW != 5'd0))
         ForwardAE = 2'b01;
   end

   always_comb begin
      ForwardBE = 2'b00;
      if (RegWriteM && (RdM == Rs2E) && (RdM != 5'd0))
         ForwardBE = 2'b10;
      else if (RegWriteW && (RdW == Rs2E) && (RdW != 5'd0))
         ForwardBE = 2'b01;
   end

   assign lwStall = LoadE && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));
   assign mcStall = ((state_q == IDLE) && MultiE) || (state_q == BUSY);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (MultiE) begin
               state_d = C_FIRST_STATE;
               cnt_d   = C_CNT_INIT;
            end
         end
         BUSY: begin
            cnt_d = cnt_q - C_CNT_ONE;
            if (cnt_q == C_CNT_ONE)
               state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign StallF = lwStall || mcStall;
   assign StallD = lwStall || mcStall;
   assign StallE = mcStall;
   assign FlushM = mcStall;
   assign FlushD = PCSrcE && !mcStall;
   assign FlushE = (lwStall || PCSrcE) && !mcStall;
   assign BusyE  = (state_q == BUSY) || (state_q == DONE);

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (StallF) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (FlushE) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign StallCycles = stall_cnt_q;
   assign FlushCount  = flush_cnt_q;
`endif

endmodule
`default_nettype wire
